// File: rtl/gpu_cmd_pkg.sv
//============================================================================
// Module      : gpu_cmd_pkg
// Description : Shared types, opcode ranges and packet sizing for the GP0
//               command packet transmitter.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package gpu_cmd_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        K_NOP  = 3'd0,
        K_FILL = 3'd1,
        K_POLY = 3'd2,
        K_LINE = 3'd3,
        K_RECT = 3'd4,
        K_COPY = 3'd5,
        K_ATTR = 3'd6,
        K_BAD  = 3'd7
    } kind_t;

    localparam logic [7:0]  c_CMD_NOP    = 8'h00;
    localparam logic [7:0]  c_CMD_FILL   = 8'h02;
    localparam logic [7:0]  c_POLY_LO    = 8'h20;
    localparam logic [7:0]  c_POLY_HI    = 8'h3F;
    localparam logic [7:0]  c_LINE_LO    = 8'h40;
    localparam logic [7:0]  c_LINE_HI    = 8'h5F;
    localparam logic [7:0]  c_RECT_LO    = 8'h60;
    localparam logic [7:0]  c_RECT_HI    = 8'h7F;
    localparam logic [7:0]  c_COPY_LO    = 8'h80;
    localparam logic [7:0]  c_COPY_HI    = 8'h9F;
    localparam logic [7:0]  c_ATTR_LO    = 8'hE1;
    localparam logic [7:0]  c_ATTR_HI    = 8'hE6;
    localparam logic [31:0] c_TERMINATOR = 32'h5555_5555;

    // Multiline (line range with bit3 set) is deliberately left unsupported.
    function automatic kind_t cmdKind(input logic [7:0] cmd);
        kind_t k;
        if (cmd == c_CMD_NOP)                            k = K_NOP;
        else if (cmd == c_CMD_FILL)                      k = K_FILL;
        else if (cmd >= c_POLY_LO && cmd <= c_POLY_HI)   k = K_POLY;
        else if (cmd >= c_LINE_LO && cmd <= c_LINE_HI)   k = cmd[3] ? K_BAD : K_LINE;
        else if (cmd >= c_RECT_LO && cmd <= c_RECT_HI)   k = K_RECT;
        else if (cmd >= c_COPY_LO && cmd <= c_COPY_HI)   k = K_COPY;
        else if (cmd >= c_ATTR_LO && cmd <= c_ATTR_HI)   k = K_ATTR;
        else                                             k = K_BAD;
        return k;
    endfunction

    function automatic logic [3:0] wordCount(input logic [7:0] cmd);
        logic [3:0] w_nv;
        logic [3:0] w_tex;
        logic [3:0] w_gour;
        logic [3:0] w_var;
        logic [3:0] w_cnt;
        w_nv   = cmd[3] ? 4'd4 : 4'd3;
        w_tex  = {3'b000, cmd[2]};
        w_gour = {3'b000, cmd[4]};
        w_var  = {3'b000, (cmd[4:3] == 2'b00)};
        case (cmdKind(cmd))
            K_POLY:  w_cnt = 4'd1 + w_nv + (cmd[2] ? w_nv : 4'd0)
                             + (cmd[4] ? (w_nv - 4'd1) : 4'd0);
            K_LINE:  w_cnt = 4'd3 + w_gour;
            K_RECT:  w_cnt = 4'd2 + w_tex + w_var;
            K_FILL:  w_cnt = 4'd3;
            K_COPY:  w_cnt = 4'd4;
            K_NOP:   w_cnt = 4'd1;
            K_ATTR:  w_cnt = 4'd1;
            default: w_cnt = 4'd0;
        endcase
        return w_cnt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gpu_cmd_word_sel.sv
//============================================================================
// Module      : gpu_cmd_word_sel
// Description : Combinational map from a latched primitive request and a
//               word index to the GP0 word at that position.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module gpu_cmd_word_sel
    import gpu_cmd_pkg::*;
(
    input  logic [7:0]   i_cmd,
    input  logic [95:0]  i_color,
    input  logic [127:0] i_vtx,
    input  logic [63:0]  i_uv,
    input  logic [15:0]  i_clut,
    input  logic [15:0]  i_tpage,
    input  logic [31:0]  i_size,
    input  logic [31:0]  i_src,
    input  logic [23:0]  i_attr,
    input  logic [3:0]   i_idx,
    output logic [31:0]  o_word
);

    kind_t       w_kind;
    logic        w_tex;
    logic        w_gour;
    logic [3:0]  w_j;
    logic [3:0]  w_first;
    logic [3:0]  w_stride;
    logic [3:0]  w_base;
    logic [3:0]  w_off;
    logic [1:0]  w_vert;
    logic [23:0] w_vColor;
    logic [31:0] w_vXy;
    logic [31:0] w_vUv;
    logic [31:0] w_polyWord;
    logic [31:0] w_header;

    // Vertex 0 never carries a colour word, so its group is shorter than the rest.
    always_comb begin
        w_kind   = cmdKind(i_cmd);
        w_tex    = i_cmd[2] && (w_kind == K_POLY || w_kind == K_RECT);
        w_gour   = i_cmd[4] && (w_kind == K_POLY || w_kind == K_LINE);
        w_j      = i_idx - 4'd1;
        w_first  = 4'd1 + {3'b000, w_tex};
        w_stride = w_first + {3'b000, w_gour};
        w_vert   = 2'd0;
        w_base   = 4'd0;
        if (w_j >= w_first + w_stride + w_stride) begin
            w_vert = 2'd3;
            w_base = w_first + w_stride + w_stride;
        end else if (w_j >= w_first + w_stride) begin
            w_vert = 2'd2;
            w_base = w_first + w_stride;
        end else if (w_j >= w_first) begin
            w_vert = 2'd1;
            w_base = w_first;
        end
        w_off = w_j - w_base;
    end

    always_comb begin
        w_vColor = i_color[23:0];
        w_vXy    = i_vtx[31:0];
        w_vUv    = {i_clut, i_uv[15:0]};
        case (w_vert)
            2'd1: begin
                w_vColor = i_color[47:24];
                w_vXy    = i_vtx[63:32];
                w_vUv    = {i_tpage, i_uv[31:16]};
            end
            2'd2: begin
                w_vColor = i_color[71:48];
                w_vXy    = i_vtx[95:64];
                w_vUv    = {16'h0000, i_uv[47:32]};
            end
            2'd3: begin
                w_vColor = i_color[95:72];
                w_vXy    = i_vtx[127:96];
                w_vUv    = {16'h0000, i_uv[63:48]};
            end
            default: ;
        endcase

        if (w_vert != 2'd0 && w_gour) begin
            case (w_off)
                4'd0:    w_polyWord = {8'h00, w_vColor};
                4'd1:    w_polyWord = w_vXy;
                default: w_polyWord = w_vUv;
            endcase
        end else begin
            w_polyWord = (w_off == 4'd0) ? w_vXy : w_vUv;
        end
    end

    always_comb begin
        case (w_kind)
            K_NOP, K_COPY: w_header = {i_cmd, 24'h000000};
            K_ATTR:        w_header = {i_cmd, i_attr};
            default:       w_header = {i_cmd, i_color[23:0]};
        endcase
    end

    // Indices past the end of a packet are never emitted; they read as the terminator.
    always_comb begin
        o_word = c_TERMINATOR;
        if (i_idx == 4'd0) begin
            o_word = w_header;
        end else begin
            case (w_kind)
                K_POLY: o_word = w_polyWord;
                K_LINE: begin
                    case (i_idx)
                        4'd1:    o_word = i_vtx[31:0];
                        4'd2:    o_word = w_gour ? {8'h00, i_color[47:24]} : i_vtx[63:32];
                        4'd3:    o_word = i_vtx[63:32];
                        default: ;
                    endcase
                end
                K_RECT: begin
                    case (i_idx)
                        4'd1:    o_word = i_vtx[31:0];
                        4'd2:    o_word = w_tex ? {i_clut, i_uv[15:0]} : i_size;
                        4'd3:    o_word = i_size;
                        default: ;
                    endcase
                end
                K_FILL: begin
                    case (i_idx)
                        4'd1:    o_word = i_vtx[31:0];
                        4'd2:    o_word = i_size;
                        default: ;
                    endcase
                end
                K_COPY: begin
                    case (i_idx)
                        4'd1:    o_word = i_src;
                        4'd2:    o_word = i_vtx[31:0];
                        4'd3:    o_word = i_size;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/gpu_cmd_packet_tx.sv
//============================================================================
// Module      : gpu_cmd_packet_tx
// Description : Accepts one primitive request and serialises it into a GP0
//               word stream over a valid/ready sink interface.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module gpu_cmd_packet_tx
    import gpu_cmd_pkg::*;
(
    input  logic         clk,
    input  logic         i_nrst,
    input  logic         i_req_valid,
    output logic         o_req_ready,
    input  logic [7:0]   i_cmd,
    input  logic [95:0]  i_color,
    input  logic [127:0] i_vtx,
    input  logic [63:0]  i_uv,
    input  logic [15:0]  i_clut,
    input  logic [15:0]  i_tpage,
    input  logic [31:0]  i_size,
    input  logic [31:0]  i_src,
    input  logic [23:0]  i_attr,
    output logic [31:0]  o_word,
    output logic         o_valid,
    input  logic         i_ready,
    output logic         o_err,
    output logic         o_busy
);

    state_t       r_state;
    state_t       w_nextState;
    logic [3:0]   r_idx;
    logic [3:0]   r_lastIdx;
    logic [7:0]   r_cmd;
    logic [95:0]  r_color;
    logic [127:0] r_vtx;
    logic [63:0]  r_uv;
    logic [15:0]  r_clut;
    logic [15:0]  r_tpage;
    logic [31:0]  r_size;
    logic [31:0]  r_src;
    logic [23:0]  r_attr;
    logic [31:0]  w_selWord;
    logic         w_accept;
    logic         w_beat;
    logic         w_lastBeat;

    assign w_accept   = i_req_valid && (r_state == S_IDLE);
    assign w_beat     = (r_state == S_EMIT) && i_ready;
    assign w_lastBeat = w_beat && (r_idx == r_lastIdx);

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    w_nextState = (cmdKind(i_cmd) == K_BAD) ? S_ERR : S_EMIT;
                end
            end
            S_EMIT: begin
                if (w_lastBeat) begin
                    w_nextState = S_IDLE;
                end
            end
            S_ERR:   w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_idx     <= 4'd0;
            r_lastIdx <= 4'd0;
        end else if (w_accept) begin
            r_idx     <= 4'd0;
            r_lastIdx <= wordCount(i_cmd) - 4'd1;
        end else if (w_beat) begin
            r_idx     <= r_idx + 4'd1;
        end
    end

    // The whole request is captured at accept so the source may move on at once.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_cmd   <= 8'h00;
            r_color <= '0;
            r_vtx   <= '0;
            r_uv    <= '0;
            r_clut  <= 16'h0000;
            r_tpage <= 16'h0000;
            r_size  <= 32'h0000_0000;
            r_src   <= 32'h0000_0000;
            r_attr  <= 24'h000000;
        end else if (w_accept) begin
            r_cmd   <= i_cmd;
            r_color <= i_color;
            r_vtx   <= i_vtx;
            r_uv    <= i_uv;
            r_clut  <= i_clut;
            r_tpage <= i_tpage;
            r_size  <= i_size;
            r_src   <= i_src;
            r_attr  <= i_attr;
        end
    end

    gpu_cmd_word_sel u_wordSel (
        .i_cmd   (r_cmd),
        .i_color (r_color),
        .i_vtx   (r_vtx),
        .i_uv    (r_uv),
        .i_clut  (r_clut),
        .i_tpage (r_tpage),
        .i_size  (r_size),
        .i_src   (r_src),
        .i_attr  (r_attr),
        .i_idx   (r_idx),
        .o_word  (w_selWord)
    );

    assign o_req_ready = (r_state == S_IDLE);
    assign o_valid     = (r_state == S_EMIT);
    assign o_busy      = (r_state == S_EMIT);
    assign o_err       = (r_state == S_ERR);
    assign o_word      = (r_state == S_EMIT) ? w_selWord : 32'h0000_0000;

endmodule

`default_nettype wire

// File: tb/tb_gpu_cmd_packet_tx.sv
//============================================================================
// Module      : tb_gpu_cmd_packet_tx
// Description : Self-checking bench for gpu_cmd_packet_tx: directed vector
//               table, reset/back-to-back sequences and random packets.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_gpu_cmd_packet_tx;

    logic         clk = 1'b0;
    logic         i_nrst;
    logic         i_req_valid;
    logic         o_req_ready;
    logic [7:0]   i_cmd;
    logic [95:0]  i_color;
    logic [127:0] i_vtx;
    logic [63:0]  i_uv;
    logic [15:0]  i_clut;
    logic [15:0]  i_tpage;
    logic [31:0]  i_size;
    logic [31:0]  i_src;
    logic [23:0]  i_attr;
    logic [31:0]  o_word;
    logic         o_valid;
    logic         i_ready;
    logic         o_err;
    logic         o_busy;

    always #5 clk = ~clk;

    gpu_cmd_packet_tx dut (
        .clk         (clk),
        .i_nrst      (i_nrst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_cmd       (i_cmd),
        .i_color     (i_color),
        .i_vtx       (i_vtx),
        .i_uv        (i_uv),
        .i_clut      (i_clut),
        .i_tpage     (i_tpage),
        .i_size      (i_size),
        .i_src       (i_src),
        .i_attr      (i_attr),
        .o_word      (o_word),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_err       (o_err),
        .o_busy      (o_busy)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0]   sCmd;
    logic [95:0]  sColor;
    logic [127:0] sVtx;
    logic [63:0]  sUv;
    logic [15:0]  sClut;
    logic [15:0]  sTpage;
    logic [31:0]  sSize;
    logic [31:0]  sSrc;
    logic [23:0]  sAttr;
    logic [31:0]  expQ[$];
    bit           expErr;

    typedef struct {
        logic [7:0] cmd;
        int         mode;   // 0: ready always, 1: toggle, 2: random
        int         len;    // expected word count, 0 for a rejected command
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference packet built straight from the command-format rules.
    function automatic void buildExpected();
        logic [23:0] c[4];
        logic [31:0] v[4];
        logic [15:0] u[4];
        int          nv;
        bit          tex;
        bit          gour;
        for (int i = 0; i < 4; i++) begin
            c[i] = sColor[24*i +: 24];
            v[i] = sVtx[32*i +: 32];
            u[i] = sUv[16*i +: 16];
        end
        expQ.delete();
        expErr = 1'b0;
        tex    = sCmd[2];
        gour   = sCmd[4];
        if (sCmd == 8'h00) begin
            expQ.push_back({sCmd, 24'h0});
        end else if (sCmd == 8'h02) begin
            expQ.push_back({sCmd, c[0]});
            expQ.push_back(v[0]);
            expQ.push_back(sSize);
        end else if (sCmd >= 8'h20 && sCmd <= 8'h3F) begin
            nv = sCmd[3] ? 4 : 3;
            expQ.push_back({sCmd, c[0]});
            for (int i = 0; i < nv; i++) begin
                if (gour && i > 0) expQ.push_back({8'h00, c[i]});
                expQ.push_back(v[i]);
                if (tex) begin
                    if (i == 0)      expQ.push_back({sClut, u[0]});
                    else if (i == 1) expQ.push_back({sTpage, u[1]});
                    else             expQ.push_back({16'h0, u[i]});
                end
            end
        end else if (sCmd >= 8'h40 && sCmd <= 8'h5F && !sCmd[3]) begin
            expQ.push_back({sCmd, c[0]});
            expQ.push_back(v[0]);
            if (gour) expQ.push_back({8'h00, c[1]});
            expQ.push_back(v[1]);
        end else if (sCmd >= 8'h60 && sCmd <= 8'h7F) begin
            expQ.push_back({sCmd, c[0]});
            expQ.push_back(v[0]);
            if (tex) expQ.push_back({sClut, u[0]});
            if (sCmd[4:3] == 2'b00) expQ.push_back(sSize);
        end else if (sCmd >= 8'h80 && sCmd <= 8'h9F) begin
            expQ.push_back({sCmd, 24'h0});
            expQ.push_back(sSrc);
            expQ.push_back(v[0]);
            expQ.push_back(sSize);
        end else if (sCmd >= 8'hE1 && sCmd <= 8'hE6) begin
            expQ.push_back({sCmd, sAttr});
        end else begin
            expErr = 1'b1;
        end
    endfunction

    task automatic randomSnapshot(input logic [7:0] cmd);
        sCmd   = cmd;
        sColor = {$urandom, $urandom, $urandom};
        sVtx   = {$urandom, $urandom, $urandom, $urandom};
        sUv    = {$urandom, $urandom};
        sClut  = 16'($urandom);
        sTpage = 16'($urandom);
        sSize  = $urandom;
        sSrc   = $urandom;
        sAttr  = 24'($urandom);
    endtask

    task automatic driveSnapshot();
        i_cmd = sCmd; i_color = sColor; i_vtx = sVtx; i_uv = sUv;
        i_clut = sClut; i_tpage = sTpage; i_size = sSize; i_src = sSrc; i_attr = sAttr;
    endtask

    task automatic scrambleInputs();
        i_cmd   = 8'($urandom);
        i_color = {$urandom, $urandom, $urandom};
        i_vtx   = {$urandom, $urandom, $urandom, $urandom};
        i_uv    = {$urandom, $urandom};
        i_clut  = 16'($urandom);
        i_tpage = 16'($urandom);
        i_size  = $urandom;
        i_src   = $urandom;
        i_attr  = 24'($urandom);
    endtask

    // Starts and ends at a falling edge with the block idle.
    task automatic doPacket(input logic [7:0] cmd, input int mode, input int len);
        int          k;
        int          cyc;
        int          wantLen;
        bit          prevStall;
        bit          rdy;
        logic [31:0] held;
        randomSnapshot(cmd);
        driveSnapshot();
        buildExpected();
        wantLen = (len >= 0) ? len : expQ.size();
        check("req_ready_idle", 32'(o_req_ready), 32'd1);
        i_req_valid = 1'b1;
        @(negedge clk);
        i_req_valid = 1'b0;
        scrambleInputs();
        if (expErr) begin
            check("err_pulse", 32'(o_err), 32'd1);
            check("err_no_valid", 32'(o_valid), 32'd0);
            @(negedge clk);
            check("err_clear", 32'(o_err), 32'd0);
            check("err_ready_next", 32'(o_req_ready), 32'd1);
            check("err_no_valid_next", 32'(o_valid), 32'd0);
            check("err_word_count", 32'd0, 32'(wantLen));
            return;
        end
        k = 0;
        cyc = 0;
        prevStall = 1'b0;
        held = 32'h0;
        while (o_valid && cyc < 100) begin
            check("busy_in_emit", 32'(o_busy), 32'd1);
            check("no_accept_in_emit", 32'(o_req_ready), 32'd0);
            if (prevStall) check("hold_stable", o_word, held);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2) == 1;
                default: rdy = 1'($urandom);
            endcase
            i_ready = rdy;
            if (rdy) begin
                if (k < expQ.size()) check($sformatf("word%0d_cmd%02h", k, cmd), o_word, expQ[k]);
                k++;
                prevStall = 1'b0;
            end else begin
                held = o_word;
                prevStall = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        i_ready = 1'b0;
        if (cyc >= 100) begin
            failures++;
            $display("FAIL packet_timeout cmd=%02h actual=%0d required=%0d", cmd, k, wantLen);
        end
        check($sformatf("word_count_cmd%02h", cmd), 32'(k), 32'(wantLen));
        check("idle_ready_after", 32'(o_req_ready), 32'd1);
        check("idle_busy_after", 32'(o_busy), 32'd0);
    endtask

    vec_t tbl[23];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{8'h3C, 0, 12};
        tbl[1]  = '{8'h64, 1, 4};
        tbl[2]  = '{8'h48, 0, 0};
        tbl[3]  = '{8'hA0, 0, 0};
        tbl[4]  = '{8'hE7, 0, 0};
        tbl[5]  = '{8'h02, 0, 3};
        tbl[6]  = '{8'hE3, 0, 1};
        tbl[7]  = '{8'h00, 2, 1};
        tbl[8]  = '{8'h80, 2, 4};
        tbl[9]  = '{8'h20, 1, 4};
        tbl[10] = '{8'h28, 2, 5};
        tbl[11] = '{8'h24, 0, 7};
        tbl[12] = '{8'h30, 2, 6};
        tbl[13] = '{8'h40, 0, 3};
        tbl[14] = '{8'h60, 1, 3};
        tbl[15] = '{8'h68, 0, 2};
        tbl[16] = '{8'h7C, 1, 3};
        tbl[17] = '{8'h01, 0, 0};
        tbl[18] = '{8'hE0, 0, 0};
        tbl[19] = '{8'hE6, 2, 1};
        tbl[20] = '{8'h5A, 0, 0};
        tbl[21] = '{8'h34, 2, 9};
        tbl[22] = '{8'h38, 0, 8};

        i_nrst = 1'b0;
        i_req_valid = 1'b0;
        i_ready = 1'b0;
        scrambleInputs();
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_word", o_word, 32'd0);
        check("rst_req_ready", 32'(o_req_ready), 32'd1);
        i_nrst = 1'b1;
        @(negedge clk);

        // Fill then attribute run back-to-back with no gap.
        for (int t = 0; t < 23; t++) begin
            doPacket(tbl[t].cmd, tbl[t].mode, tbl[t].len);
        end

        // Reset in the middle of a flat triangle, then a gouraud line.
        randomSnapshot(8'h20);
        driveSnapshot();
        buildExpected();
        i_req_valid = 1'b1;
        @(negedge clk);
        i_req_valid = 1'b0;
        i_ready = 1'b1;
        check("mid_word0", o_word, expQ[0]);
        @(negedge clk);
        check("mid_word1", o_word, expQ[1]);
        @(negedge clk);
        i_nrst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(o_valid), 32'd0);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_word", o_word, 32'd0);
        @(negedge clk);
        i_nrst = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("post_rst_quiet", 32'(o_valid), 32'd0);
        end
        i_ready = 1'b0;
        doPacket(8'h50, 0, 4);

        for (int r = 0; r < 80; r++) begin
            logic [7:0] rc;
            rc = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom_range(32, 159));
            doPacket(rc, int'($urandom_range(0, 2)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
